// File: rtl/toplevel.sv
// Small 16-bit multicycle RISC core with a fixed program ROM, an 8x16 register file,
// a 16x16 data RAM and a four-digit active-low anode scanner.
module toplevel #(
    parameter int IMEM_WORDS = 16,
    parameter int DMEM_WORDS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk1,
    input  logic       sw,
    output logic [3:0] an
);
    localparam int PCW = $clog2(IMEM_WORDS);
    localparam int AW  = $clog2(DMEM_WORDS);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t             state_r;
    state_t             state_next_s;
    logic [PCW-1:0]     pc_r;
    logic [15:0]        ir_r;
    logic [15:0]        a_r;
    logic [15:0]        b_r;
    logic [15:0]        imm_r;
    logic [15:0]        alu_r;
    logic [15:0]        alu_s;
    logic [15:0]        regs_r [8];
    logic [15:0]        dmem_r [DMEM_WORDS];
    logic [1:0]         idx_r;
    logic [3:0]         an_scan_r;
    logic [3:0]         op_s;

    function automatic logic [15:0] rom_word(input logic [7:0] addr);
        case (addr)
            8'd0:    rom_word = 16'h4205;
            8'd1:    rom_word = 16'h4403;
            8'd2:    rom_word = 16'h0650;
            8'd3:    rom_word = 16'h1850;
            8'd4:    rom_word = 16'h6600;
            8'd5:    rom_word = 16'h5A00;
            8'd6:    rom_word = 16'h7741;
            8'd7:    rom_word = 16'h4C01;
            default: rom_word = 16'hF000;
        endcase
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        sext6 = {{10{v[5]}}, v};
    endfunction

    function automatic logic [3:0] onehot_n(input logic [1:0] i);
        onehot_n = ~(4'b0001 << i);
    endfunction

    assign op_s = ir_r[15:12];

    // Control state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state sequencing; BEQ and NOP leave from EXEC, SW leaves from MEM
    always_comb begin
        state_next_s = ST_FETCH;
        case (state_r)
            ST_FETCH:  state_next_s = ST_DECODE;
            ST_DECODE: begin
                if (op_s == OP_HALT) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: state_next_s = ST_WB;
                    OP_LW, OP_SW:                           state_next_s = ST_MEM;
                    default:                                state_next_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (op_s == OP_LW) begin
                    state_next_s = ST_WB;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_WB:     state_next_s = ST_FETCH;
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_FETCH;
        endcase
    end

    // ALU: loads and stores reuse the immediate adder for their address
    always_comb begin
        alu_s = 16'h0000;
        case (op_s)
            OP_ADD:               alu_s = a_r + b_r;
            OP_SUB:               alu_s = a_r - b_r;
            OP_AND:               alu_s = a_r & b_r;
            OP_OR:                alu_s = a_r | b_r;
            OP_ADDI, OP_LW, OP_SW: alu_s = a_r + imm_r;
            default:              alu_s = 16'h0000;
        endcase
    end

    // Datapath registers, register file and data RAM
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r  <= '0;
            ir_r  <= 16'h0000;
            a_r   <= 16'h0000;
            b_r   <= 16'h0000;
            imm_r <= 16'h0000;
            alu_r <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= 16'h0000;
            end
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem_r[i] <= 16'h0000;
            end
        end else begin
            case (state_r)
                ST_FETCH: begin
                    ir_r <= rom_word(8'(pc_r));
                    pc_r <= pc_r + {{(PCW-1){1'b0}}, 1'b1};
                end
                ST_DECODE: begin
                    a_r   <= regs_r[ir_r[8:6]];
                    // SW stores rd and BEQ compares rd, so B comes from rd for those
                    if (op_s == OP_SW || op_s == OP_BEQ) begin
                        b_r <= regs_r[ir_r[11:9]];
                    end else begin
                        b_r <= regs_r[ir_r[5:3]];
                    end
                    imm_r <= sext6(ir_r[5:0]);
                end
                ST_EXEC: begin
                    alu_r <= alu_s;
                    if (op_s == OP_BEQ && a_r == b_r) begin
                        pc_r <= pc_r + imm_r[PCW-1:0];
                    end
                end
                ST_MEM: begin
                    if (op_s == OP_LW) begin
                        alu_r <= dmem_r[alu_r[AW-1:0]];
                    end
                    if (op_s == OP_SW) begin
                        dmem_r[alu_r[AW-1:0]] <= b_r;
                    end
                end
                ST_WB: begin
                    if (ir_r[11:9] != 3'd0) begin
                        regs_r[ir_r[11:9]] <= alu_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Anode scanner, independent of the core
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_r     <= 2'd0;
            an_scan_r <= 4'b1110;
        end else if (clk1) begin
            idx_r     <= idx_r + 2'd1;
            an_scan_r <= onehot_n(idx_r + 2'd1);
        end
    end

    // Mode mux: r3 low nibble is shown directly when sw is high
    always_comb begin
        if (sw) begin
            an = ~regs_r[3][3:0];
        end else begin
            an = an_scan_r;
        end
    end

endmodule

// File: tb/tb_toplevel.sv
// Scoreboard bench for toplevel: stimulus pushes expected values, a monitor pops
// and compares them against the anode bus and internal core state.
module tb_toplevel;
    logic       clk;
    logic       rst;
    logic       clk1;
    logic       sw;
    logic [3:0] an;

    localparam int S_AN  = 0;
    localparam int S_PC  = 1;
    localparam int S_REG = 2;
    localparam int S_MEM = 3;
    localparam int S_ST  = 4;

    typedef struct {
        string       nm;
        int          sel;
        int          idx;
        logic [15:0] exp;
    } item_t;

    item_t q[$];
    int    total;
    int    bad;

    toplevel dut (
        .clk  (clk),
        .rst  (rst),
        .clk1 (clk1),
        .sw   (sw),
        .an   (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] observe(input int sel, input int idx);
        logic [15:0] v;
        case (sel)
            S_AN:    v = {12'h000, an};
            S_PC:    v = {12'h000, dut.pc_r};
            S_REG:   v = dut.regs_r[idx];
            S_MEM:   v = dut.dmem_r[idx];
            S_ST:    v = {13'h0000, dut.state_r};
            default: v = 16'hxxxx;
        endcase
        return v;
    endfunction

    task automatic push(input string nm, input int sel, input int idx, input logic [15:0] exp);
        item_t it;
        it.nm  = nm;
        it.sel = sel;
        it.idx = idx;
        it.exp = exp;
        q.push_back(it);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic final_checks(input string tag);
        push({tag, "_state"}, S_ST, 0, 16'd5);
        push({tag, "_pc"}, S_PC, 0, 16'd9);
        push({tag, "_r0"}, S_REG, 0, 16'd0);
        push({tag, "_r1"}, S_REG, 1, 16'd5);
        push({tag, "_r2"}, S_REG, 2, 16'd3);
        push({tag, "_r3"}, S_REG, 3, 16'd8);
        push({tag, "_r4"}, S_REG, 4, 16'd2);
        push({tag, "_r5"}, S_REG, 5, 16'd8);
        push({tag, "_r6"}, S_REG, 6, 16'd0);
        push({tag, "_r7"}, S_REG, 7, 16'd0);
        push({tag, "_m0"}, S_MEM, 0, 16'd8);
    endtask

    // Monitor: compare every queued expectation on the falling edge
    initial begin
        item_t       it;
        logic [15:0] got;
        total = 0;
        bad   = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                it    = q.pop_front();
                got   = observe(it.sel, it.idx);
                total = total + 1;
                if (got !== it.exp) begin
                    bad = bad + 1;
                    $display("FAIL %s: got %h expected %h", it.nm, got, it.exp);
                end
            end
        end
    end

    initial begin
        logic [3:0] scan_seq [5];
        int         waited;
        scan_seq[0] = 4'b1101;
        scan_seq[1] = 4'b1011;
        scan_seq[2] = 4'b0111;
        scan_seq[3] = 4'b1110;
        scan_seq[4] = 4'b1101;

        rst  = 1'b0;
        sw   = 1'b0;
        clk1 = 1'b0;
        step(2);
        push("rst_an_scan", S_AN, 0, 16'h000E);
        push("rst_pc", S_PC, 0, 16'd0);
        push("rst_state", S_ST, 0, 16'd0);
        step(1);
        sw = 1'b1;
        push("rst_an_r3", S_AN, 0, 16'h000F);
        step(1);
        sw = 1'b0;

        // Release reset; edge k below is execution cycle k
        rst = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step(1);
            case (cyc)
                3:  push("c3_r1_old", S_REG, 1, 16'd0);
                4:  push("c4_r1_new", S_REG, 1, 16'd5);
                7:  push("c7_r2_old", S_REG, 2, 16'd0);
                8:  push("c8_r2_new", S_REG, 2, 16'd3);
                24: push("c24_r5_old", S_REG, 5, 16'd0);
                25: push("c25_r5_new", S_REG, 5, 16'd8);
                28: begin
                    push("c28_fetch", S_ST, 0, 16'd0);
                    push("c28_pc8", S_PC, 0, 16'd8);
                end
                29: push("c29_decode", S_ST, 0, 16'd1);
                30: push("c30_halted", S_ST, 0, 16'd5);
                default: begin
                end
            endcase
        end
        final_checks("run1");
        push("run1_an_idle", S_AN, 0, 16'h000E);

        step(1);
        sw = 1'b1;
        push("sw1_an", S_AN, 0, 16'h0007);
        step(1);
        sw = 1'b0;
        push("sw0_an", S_AN, 0, 16'h000E);

        clk1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            push($sformatf("scan_%0d", k), S_AN, 0, {12'h000, scan_seq[k]});
        end
        clk1 = 1'b0;
        step(3);
        push("scan_hold", S_AN, 0, 16'h000D);

        // Full reset again, then reset mid-execution at cycle 10
        rst = 1'b0;
        step(1);
        push("rst2_an", S_AN, 0, 16'h000E);
        push("rst2_r3", S_REG, 3, 16'd0);
        push("rst2_m0", S_MEM, 0, 16'd0);
        rst = 1'b1;
        step(9);
        push("c9_r2", S_REG, 2, 16'd3);
        rst = 1'b0;
        step(1);
        push("mid_rst_r1", S_REG, 1, 16'd0);
        push("mid_rst_r2", S_REG, 2, 16'd0);
        push("mid_rst_pc", S_PC, 0, 16'd0);
        push("mid_rst_state", S_ST, 0, 16'd0);
        rst = 1'b1;
        step(40);
        final_checks("run2");

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited = waited + 1;
        end
        #1;
        if (q.size() > 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: pending %0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
